spi_target_rx: RTL and testbench
================================

# spi_target_rx

SPI mode-0 target (responder) that receives MSB-first bytes from the on-chip SPI controller or an external master over SCK/SDI/CSX. It returns a response byte on SDO. All SPI pins are asynchronous to CLK_100MHz and are oversampled through synchronizers. The block sits between the SPI pins and the system-clock domain. It delivers each received byte through a valid/ack handshake and takes response bytes through a one-deep transmit buffer.

## Interface
- SYNC_STAGES, 2: synchronizer flops per SPI input; minimum 2.
- TX_IDLE_BYTE, 8'hFF: byte shifted out when the transmit buffer is empty.

- CLK_100MHz  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- SCK  in  1  SPI clock (async).
- SDI  in  1  SPI data from master (async).
- CSX  in  1  chip select, active low (async).
- SDO  out  1  SPI data to master.
- out  out  8  last received byte; held stable while out_valid=1.
- out_valid  out  1  received byte pending.
- out_ack  in  1  consumer accepts `out`.
- tx_data  in  8  response byte.
- tx_load  in  1  write tx_data into the transmit buffer.
- tx_ready  out  1  transmit buffer empty.
- overrun  out  1  sticky: a byte completed while out_valid=1.
- frame_err  out  1  sticky: CSX deasserted mid-byte.
- err_clr  in  1  clears overrun and frame_err.

## Operation
- **Input synchronization.** SCK, SDI and CSX each pass through SYNC_STAGES flops plus one history flop for edge detection.
  - Reset values of the synchronizer chains: SCK=0, SDI=0, CSX=1.
  - sck_rise, sck_fall and csx_fall are single-cycle strobes derived from the synchronized signals.
- **States:**
  - DISARMED (reset state): go to IDLE once synchronized CSX=1. A select already asserted at reset release is ignored until it deasserts.
  - IDLE: on csx_fall, set bit_cnt=0 and load tx_shift from the transmit buffer (TX_IDLE_BYTE if the buffer is empty). The buffer becomes empty, so tx_ready=1. Drive SDO<=bit 7 of the loaded byte. Go to ACTIVE.
  - ACTIVE, sck_rise: rx_shift<={rx_shift[6:0], SDI_sync}, bit_cnt+1.
  - ACTIVE, sck_rise with bit_cnt=7 (byte completes):
    - If out_valid=0 or out_ack=1 this cycle, write out<=completed byte and set out_valid=1.
    - Otherwise keep the old `out` and set overrun=1.
    - Set bit_cnt=0 and reload tx_shift from the buffer (or TX_IDLE_BYTE), emptying the buffer.
  - ACTIVE, sck_fall: SDO<=tx_shift[7-bit_cnt]. With bit_cnt=0 this presents bit 7 of the next byte.
  - ACTIVE, CSX synchronized high: go to IDLE. If bit_cnt≠0, discard the partial byte and set frame_err=1. SDO returns to 1.
- **Receive handshake.** out_valid clears on the cycle out_ack=1. out_ack while out_valid=0 is ignored. A completion in the same cycle as out_ack succeeds with no overrun; out_valid stays 1 and `out` holds the new byte.
- **Transmit buffer.**
  - tx_load with tx_ready=1 captures tx_data and sets tx_ready=0.
  - tx_load with tx_ready=0 is ignored; the buffer is not overwritten.
  - tx_load in the same cycle the buffer is consumed: consumption takes the old contents, then tx_data is captured.
- **Error flags.**
  - err_clr clears both sticky flags.
  - A flag set in the same cycle as err_clr wins, so the flag stays 1.
- **Reset.** Any cycle with reset_n=0 at the clock edge resets the block, mid-frame included. Reset state:
  - state DISARMED, bit_cnt=0.
  - out=0, out_valid=0, overrun=0, frame_err=0.
  - tx_ready=1, transmit buffer empty.
  - SDO=1.
  - The synchronizer chains take the values listed under input synchronization.

## Timing
- Pin edge to internal strobe latency: SYNC_STAGES+1 cycles (3 at the default).
- SDI is sampled on the same cycle as the delayed SCK rise. SDI must be stable from SYNC_STAGES+1 cycles before the pin SCK rise until that edge is consumed.
- SCK high and low phases must each be ≥ SYNC_STAGES+2 system clocks. At 100 MHz with defaults this allows SCK ≤ 12.5 MHz.
- out_valid rises 1 cycle after the strobe of the 8th sck_rise, i.e. 4 cycles after the pin edge at default settings.
- SDO changes 4 cycles after the pin SCK fall. The master must sample SDO on its next rising edge.
- CSX high must last ≥ SYNC_STAGES+2 cycles between frames.
- Back-to-back bytes within one CSX frame are supported with no gap.

## Test plan
- Reset, CSX high, then a frame of 0xA5 at 1 MHz SCK -> out=0xA5, out_valid=1 until out_ack, overrun=0, frame_err=0.
- tx_load 0x3C before CSX falls; master sends 0x00 -> master samples 0x3C on SDO; tx_ready=1 right after csx_fall. A second byte in the same frame with the buffer empty -> SDO carries 0xFF.
- Two bytes 0x12, 0x34 in one frame; out_ack never asserted -> out=0x12, overrun=1. Repeat with out_ack pulsed on the 2nd completion cycle -> out=0x34, overrun=0.
- CSX deasserted after 5 SCK rises -> no out_valid, frame_err=1. Then err_clr -> frame_err=0. The next full frame of 0x81 is received correctly.
- Hold CSX low through reset release, then send 0x55 -> ignored (DISARMED). After CSX goes high, a new frame of 0x55 -> received.
- Assert reset_n=0 mid-byte (after 3 bits) -> all outputs return to their reset values the next cycle, bit_cnt=0, and no stale partial bits appear in the next received byte.

Source files
------------

// File: rtl/spi_target_rx.sv
// spi_target_rx: SPI mode-0 target. All SPI pins are oversampled in the system
// clock domain. Received bytes leave through a valid/ack handshake, and response
// bytes enter through a one-deep transmit buffer.
module spi_target_rx #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
  input  logic       CLK_100MHz,
  input  logic       reset_n,
  input  logic       SCK,
  input  logic       SDI,
  input  logic       CSX,
  output logic       SDO,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       overrun,
  output logic       frame_err,
  input  logic       err_clr
);

  localparam logic [1:0] S_DISARMED = 2'd0;
  localparam logic [1:0] S_IDLE     = 2'd1;
  localparam logic [1:0] S_ACTIVE   = 2'd2;

  // Cycles after reset until the history flops hold real pin samples rather
  // than reset values; before that the select line cannot be trusted.
  localparam logic [3:0] FLUSH_CNT = 4'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_csx_sync;
  logic                   r_sck_hist;
  logic                   r_sdi_hist;
  logic                   r_csx_hist;
  logic                   r_sck_rise;
  logic                   r_sck_fall;
  logic                   r_csx_fall;

  logic [1:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_flush;
  logic       r_sdo;
  logic [7:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic [7:0] r_out;
  logic       r_out_valid;
  logic       r_overrun;
  logic       r_frame_err;
  logic       r_tx_full;
  logic [7:0] r_tx_buf;

  logic       w_sck_s;
  logic       w_sdi_s;
  logic       w_csx_s;
  logic       w_csx_hi;
  logic [7:0] w_buf_byte;
  logic       w_start;
  logic       w_end;
  logic       w_shift;
  logic       w_done;
  logic       w_fall;
  logic       w_take;
  logic [7:0] w_rx_next;

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi_s    = r_sdi_sync[SYNC_STAGES-1];
  assign w_csx_s    = r_csx_sync[SYNC_STAGES-1];
  assign w_csx_hi   = r_csx_hist;
  assign w_buf_byte = r_tx_full ? r_tx_buf : TX_IDLE_BYTE;
  assign w_start    = (r_state == S_IDLE) && r_csx_fall;
  assign w_end      = (r_state == S_ACTIVE) && w_csx_hi;
  assign w_shift    = (r_state == S_ACTIVE) && !w_csx_hi && r_sck_rise;
  assign w_done     = w_shift && (r_bit_cnt == 3'd7);
  assign w_fall     = (r_state == S_ACTIVE) && !w_csx_hi && r_sck_fall;
  assign w_take     = w_start || w_done;
  // SDI history is aligned with the cycle on which the SCK rise strobe is seen.
  assign w_rx_next  = {r_rx_shift[6:0], r_sdi_hist};

  assign SDO       = r_sdo;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign tx_ready  = ~r_tx_full;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

  // Synchronizer chains and history flops for the asynchronous pins.
  always_ff @(posedge CLK_100MHz) begin
    if (!reset_n) begin
      r_sck_sync <= '0;
      r_sdi_sync <= '0;
      r_csx_sync <= '1;
      r_sck_hist <= 1'b0;
      r_sdi_hist <= 1'b0;
      r_csx_hist <= 1'b1;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], SDI};
      r_csx_sync <= {r_csx_sync[SYNC_STAGES-2:0], CSX};
      r_sck_hist <= w_sck_s;
      r_sdi_hist <= w_sdi_s;
      r_csx_hist <= w_csx_s;
    end
  end

  // Registered single-cycle edge strobes.
  always_ff @(posedge CLK_100MHz) begin
    if (!reset_n) begin
      r_sck_rise <= 1'b0;
      r_sck_fall <= 1'b0;
      r_csx_fall <= 1'b0;
    end else begin
      r_sck_rise <= w_sck_s & ~r_sck_hist;
      r_sck_fall <= ~w_sck_s & r_sck_hist;
      r_csx_fall <= ~w_csx_s & r_csx_hist;
    end
  end

  // Frame state machine, bit counter and SDO driver.
  always_ff @(posedge CLK_100MHz) begin
    if (!reset_n) begin
      r_state   <= S_DISARMED;
      r_bit_cnt <= 3'd0;
      r_flush   <= 4'd0;
      r_sdo     <= 1'b1;
    end else begin
      if (r_flush != FLUSH_CNT) r_flush <= r_flush + 4'd1;
      case (r_state)
        S_DISARMED: begin
          r_sdo <= 1'b1;
          if ((r_flush == FLUSH_CNT) && w_csx_hi) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_start) begin
            r_bit_cnt <= 3'd0;
            r_sdo     <= w_buf_byte[7];
            r_state   <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (w_end) begin
            r_bit_cnt <= 3'd0;
            r_sdo     <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end else if (w_fall) begin
            r_sdo <= r_tx_shift[3'd7 - r_bit_cnt];
          end
        end
        default: begin
          r_state   <= S_DISARMED;
          r_bit_cnt <= 3'd0;
          r_sdo     <= 1'b1;
        end
      endcase
    end
  end

  // Receive and transmit shift registers (data only, flushed by bit_cnt).
  always_ff @(posedge CLK_100MHz) begin
    if (w_shift) r_rx_shift <= w_rx_next;
    if (w_take)  r_tx_shift <= w_buf_byte;
  end

  // Receive handshake and overrun detection.
  always_ff @(posedge CLK_100MHz) begin
    if (!reset_n) begin
      r_out       <= 8'h00;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_done && (!r_out_valid || out_ack)) begin
        r_out       <= w_rx_next;
        r_out_valid <= 1'b1;
      end else if (out_ack) begin
        r_out_valid <= 1'b0;
      end
      if (w_done && r_out_valid && !out_ack) r_overrun <= 1'b1;
      else if (err_clr)                      r_overrun <= 1'b0;
    end
  end

  // Sticky framing error: select released with a partial byte shifted in.
  always_ff @(posedge CLK_100MHz) begin
    if (!reset_n) begin
      r_frame_err <= 1'b0;
    end else if (w_end && (r_bit_cnt != 3'd0)) begin
      r_frame_err <= 1'b1;
    end else if (err_clr) begin
      r_frame_err <= 1'b0;
    end
  end

  // One-deep transmit buffer occupancy; consumption happens before a same-cycle load.
  always_ff @(posedge CLK_100MHz) begin
    if (!reset_n) begin
      r_tx_full <= 1'b0;
    end else if (w_take) begin
      r_tx_full <= tx_load;
    end else if (tx_load) begin
      r_tx_full <= 1'b1;
    end
  end

  // Transmit buffer contents.
  always_ff @(posedge CLK_100MHz) begin
    if (tx_load && (!r_tx_full || w_take)) r_tx_buf <= tx_data;
  end

endmodule

// File: tb/tb_spi_target_rx.sv
// Bench for spi_target_rx: directed SPI frames driven at 1 MHz SCK, an
// event-level reference model of the target, and a per-cycle compare process.
`timescale 1ns/1ps
module tb_spi_target_rx;

  localparam int HALF   = 50;   // SCK half period in system clocks
  localparam int SETTLE = 8;    // cycles for a pin event to reach the outputs

  logic       clk = 1'b0;
  logic       reset_n;
  logic       SCK, SDI, CSX;
  logic       SDO;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ack;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic       overrun;
  logic       frame_err;
  logic       err_clr;

  int n_assert = 0;
  int n_fail   = 0;
  int settle   = SETTLE;
  bit chk_on   = 1'b0;

  // Reference model state, updated at pin / handshake events.
  bit         m_armed, m_active, m_valid, m_ovr, m_ferr, m_full;
  int         m_cnt;
  logic [7:0] m_rx, m_txs, m_out, m_buf;
  logic       m_sdo;

  logic [7:0] miso;

  spi_target_rx dut (
    .CLK_100MHz(clk), .reset_n(reset_n), .SCK(SCK), .SDI(SDI), .CSX(CSX),
    .SDO(SDO), .out(out), .out_valid(out_valid), .out_ack(out_ack),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .overrun(overrun), .frame_err(frame_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (settle > 0) settle = settle - 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model once outputs have settled.
  always @(negedge clk) begin
    if (chk_on && settle == 0) begin
      chk("out", out, m_out);
      chk("out_valid", {7'd0, out_valid}, {7'd0, m_valid});
      chk("overrun", {7'd0, overrun}, {7'd0, m_ovr});
      chk("frame_err", {7'd0, frame_err}, {7'd0, m_ferr});
      chk("tx_ready", {7'd0, tx_ready}, {7'd0, ~m_full});
      chk("SDO", {7'd0, SDO}, {7'd0, m_sdo});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_armed = 1'b0; m_active = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
    m_ferr = 1'b0; m_full = 1'b0; m_cnt = 0; m_out = 8'h00; m_sdo = 1'b1;
  endtask

  task automatic m_rise(input logic d, input bit ack);
    if (m_active) begin
      m_rx = {m_rx[6:0], d};
      m_cnt++;
      if (m_cnt == 8) begin
        m_cnt = 0;
        if (!m_valid || ack) begin m_out = m_rx; m_valid = 1'b1; end
        else m_ovr = 1'b1;
        m_txs = m_full ? m_buf : 8'hFF;
        m_full = 1'b0;
      end
    end
  endtask

  task automatic csx_low();
    CSX = 1'b0; settle = SETTLE;
    if (m_armed && !m_active) begin
      m_active = 1'b1; m_cnt = 0;
      m_txs = m_full ? m_buf : 8'hFF;
      m_full = 1'b0;
      m_sdo = m_txs[7];
    end
  endtask

  task automatic csx_high();
    CSX = 1'b1; settle = SETTLE;
    if (m_active) begin
      if (m_cnt != 0) m_ferr = 1'b1;
      m_active = 1'b0;
      m_sdo = 1'b1;
    end
    m_armed = 1'b1;
  endtask

  // Send the top nbits of mosi MSB first; miso collects what SDO showed.
  task automatic spi_bits(input logic [7:0] mosi, input int nbits, input bit ack_last,
                          input bit probe, output logic [7:0] so);
    so = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      SDI = mosi[i];
      wait_cyc(HALF);
      so[i] = SDO;
      SCK = 1'b1; settle = SETTLE;
      m_rise(mosi[i], ack_last && i == 0);
      if (i == 0 && ack_last) begin
        wait_cyc(3); out_ack = 1'b1;
        wait_cyc(1); out_ack = 1'b0;
        wait_cyc(HALF - 4);
      end else if (i == 0 && probe) begin
        wait_cyc(3); chk("latency_pre", {7'd0, out_valid}, 8'h00);
        wait_cyc(1); chk("latency_post", {7'd0, out_valid}, 8'h01);
        wait_cyc(HALF - 4);
      end else begin
        wait_cyc(HALF);
      end
      SCK = 1'b0; settle = SETTLE;
      if (m_active) m_sdo = m_txs[7 - m_cnt];
    end
  endtask

  task automatic pulse_ack();
    out_ack = 1'b1; settle = SETTLE;
    m_valid = 1'b0;
    wait_cyc(1); out_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; settle = SETTLE;
    m_ovr = 1'b0; m_ferr = 1'b0;
    wait_cyc(1); err_clr = 1'b0;
  endtask

  task automatic load_tx(input logic [7:0] d);
    tx_data = d; tx_load = 1'b1; settle = SETTLE;
    if (!m_full) begin m_buf = d; m_full = 1'b1; end
    wait_cyc(1); tx_load = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input bit probe);
    csx_low(); wait_cyc(20);
    spi_bits(d, 8, 1'b0, probe, miso);
    wait_cyc(20); csx_high(); wait_cyc(20);
  endtask

  task automatic do_reset(input logic csx_lvl);
    reset_n = 1'b0; CSX = csx_lvl; SCK = 1'b0; settle = SETTLE;
    m_reset();
    wait_cyc(5);
    reset_n = 1'b1; settle = SETTLE;
    m_armed = csx_lvl;
    wait_cyc(10);
  endtask

  initial begin
    SCK = 1'b0; SDI = 1'b0; CSX = 1'b1; out_ack = 1'b0; tx_data = 8'h00;
    tx_load = 1'b0; err_clr = 1'b0; m_rx = 8'h00; m_txs = 8'hFF; m_buf = 8'h00;
    do_reset(1'b1);
    chk("rst_out", out, 8'h00);
    chk("rst_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_tx_ready", {7'd0, tx_ready}, 8'h01);
    chk("rst_sdo", {7'd0, SDO}, 8'h01);
    chk("rst_overrun", {7'd0, overrun}, 8'h00);
    chk_on = 1'b1;

    // Single byte 0xA5 with handshake
    frame(8'hA5, 1'b1);
    chk("a5_out", out, 8'hA5);
    chk("a5_valid", {7'd0, out_valid}, 8'h01);
    chk("a5_ferr", {7'd0, frame_err}, 8'h00);
    pulse_ack(); wait_cyc(10);
    chk("a5_acked", {7'd0, out_valid}, 8'h00);

    // Response byte 0x3C, a second load ignored, then idle byte on second byte
    load_tx(8'h3C); load_tx(8'h99); wait_cyc(5);
    chk("tx_full", {7'd0, tx_ready}, 8'h00);
    csx_low(); wait_cyc(10);
    chk("tx_ready_after_sel", {7'd0, tx_ready}, 8'h01);
    wait_cyc(10);
    spi_bits(8'h00, 8, 1'b0, 1'b0, miso);
    chk("miso_3c", miso, 8'h3C);
    spi_bits(8'h00, 8, 1'b0, 1'b0, miso);
    chk("miso_ff", miso, 8'hFF);
    wait_cyc(20); csx_high(); wait_cyc(20);
    pulse_ack(); pulse_clr(); wait_cyc(10);

    // Overrun: two bytes, no ack
    csx_low(); wait_cyc(20);
    spi_bits(8'h12, 8, 1'b0, 1'b0, miso);
    spi_bits(8'h34, 8, 1'b0, 1'b0, miso);
    wait_cyc(20); csx_high(); wait_cyc(20);
    chk("ovr_out", out, 8'h12);
    chk("ovr_flag", {7'd0, overrun}, 8'h01);
    pulse_ack(); pulse_clr(); wait_cyc(10);

    // Ack coincident with the second completion
    csx_low(); wait_cyc(20);
    spi_bits(8'h12, 8, 1'b0, 1'b0, miso);
    spi_bits(8'h34, 8, 1'b1, 1'b0, miso);
    wait_cyc(20); csx_high(); wait_cyc(20);
    chk("ack_out", out, 8'h34);
    chk("ack_ovr", {7'd0, overrun}, 8'h00);
    chk("ack_valid", {7'd0, out_valid}, 8'h01);
    pulse_ack(); wait_cyc(10);

    // Framing error after 5 bits
    csx_low(); wait_cyc(20);
    spi_bits(8'hF8, 5, 1'b0, 1'b0, miso);
    wait_cyc(20); csx_high(); wait_cyc(20);
    chk("ferr_flag", {7'd0, frame_err}, 8'h01);
    chk("ferr_novalid", {7'd0, out_valid}, 8'h00);
    pulse_clr(); wait_cyc(10);
    chk("ferr_clr", {7'd0, frame_err}, 8'h00);
    frame(8'h81, 1'b1);
    chk("after_ferr_out", out, 8'h81);
    pulse_ack(); wait_cyc(10);

    // Select held low through reset release
    do_reset(1'b0);
    spi_bits(8'h55, 8, 1'b0, 1'b0, miso);
    wait_cyc(20);
    chk("disarmed_valid", {7'd0, out_valid}, 8'h00);
    chk("disarmed_out", out, 8'h00);
    csx_high(); wait_cyc(20);
    frame(8'h55, 1'b0);
    chk("armed_out", out, 8'h55);

    // Reset mid-byte after 3 bits, with tx buffer full and out_valid set
    csx_low(); wait_cyc(20);
    load_tx(8'h77);
    spi_bits(8'hE0, 3, 1'b0, 1'b0, miso);
    reset_n = 1'b0; settle = SETTLE; m_reset();
    wait_cyc(1);
    chk("mid_rst_out", out, 8'h00);
    chk("mid_rst_valid", {7'd0, out_valid}, 8'h00);
    chk("mid_rst_tx_ready", {7'd0, tx_ready}, 8'h01);
    chk("mid_rst_sdo", {7'd0, SDO}, 8'h01);
    chk("mid_rst_ovr", {7'd0, overrun}, 8'h00);
    chk("mid_rst_ferr", {7'd0, frame_err}, 8'h00);
    wait_cyc(3);
    reset_n = 1'b1; settle = SETTLE;
    wait_cyc(10);
    csx_high(); wait_cyc(20);
    frame(8'h0F, 1'b1);
    chk("post_rst_out", out, 8'h0F);
    wait_cyc(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
